// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// controller states and iteration count.
package mdu_pkg;

   localparam logic [1:0] MDU_MULT  = 2'b00;
   localparam logic [1:0] MDU_MULTU = 2'b01;
   localparam logic [1:0] MDU_DIV   = 2'b10;
   localparam logic [1:0] MDU_DIVU  = 2'b11;

   localparam int MDU_ITERS = 32;
   localparam int MDU_CNT_W = $clog2(MDU_ITERS) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate: magnitude extraction on operands and
// sign restoration on results share this block.
module mdu_abs_neg #(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] res_o
);

   assign res_o = neg_i ? ('0 - val_i) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU with architectural HI/LO.
// Fixed 34-cycle latency: 32 shift-add / restoring-divide steps plus sign fix.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o,
   output logic             done_o
);

   mdu_state_e             state_q;
   logic [MDU_CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]       hi_q, lo_q;
   logic                   done_q;

   logic                   is_div_q, qsign_q, rsign_q;
   logic [WIDTH-1:0]       opnd_q;
   logic [2*WIDTH-1:0]     acc_q, acc_d;

   logic                   in_signed, in_div, launch;
   logic [WIDTH-1:0]       abs_a, abs_b;
   logic [2*WIDTH-1:0]     prod_fix;
   logic [WIDTH-1:0]       quo_fix, rem_fix;

   logic [WIDTH:0]         mul_sum, div_shift;
   logic [WIDTH-1:0]       div_diff;
   logic                   div_ok;

   assign in_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
   assign in_div    = (op_i == MDU_DIV)  || (op_i == MDU_DIVU);
   assign launch    = (state_q == ST_IDLE) && start_i && !flush_i;

   mdu_abs_neg #(.W(WIDTH)) u_abs_a (
      .val_i(a_i), .neg_i(in_signed && a_i[WIDTH-1]), .res_o(abs_a));
   mdu_abs_neg #(.W(WIDTH)) u_abs_b (
      .val_i(b_i), .neg_i(in_signed && b_i[WIDTH-1]), .res_o(abs_b));

   mdu_abs_neg #(.W(2*WIDTH)) u_fix_prod (
      .val_i(acc_q), .neg_i(qsign_q), .res_o(prod_fix));
   mdu_abs_neg #(.W(WIDTH)) u_fix_quo (
      .val_i(acc_q[WIDTH-1:0]), .neg_i(qsign_q), .res_o(quo_fix));
   mdu_abs_neg #(.W(WIDTH)) u_fix_rem (
      .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(rsign_q), .res_o(rem_fix));

   // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ok    = (div_shift >= {1'b0, opnd_q});
      div_diff  = div_shift[WIDTH-1:0] - opnd_q;
      acc_d     = {mul_sum, acc_q[WIDTH-1:1]};
      if (is_div_q) begin
         acc_d = div_ok ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                        : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
   end

   // Datapath registers carry no reset; they are always reloaded on launch.
   always_ff @(posedge clk_i) begin
      if (launch) begin
         is_div_q <= in_div;
         opnd_q   <= in_div ? abs_b : abs_a;
         acc_q    <= {{WIDTH{1'b0}}, (in_div ? abs_a : abs_b)};
         // A zero divisor keeps the all-ones quotient uncorrected.
         qsign_q  <= in_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]) && !(in_div && (b_i == '0));
         rsign_q  <= in_signed && a_i[WIDTH-1];
      end else if (state_q == ST_RUN) begin
         acc_q    <= acc_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (launch) begin
                  cnt_q   <= '0;
                  state_q <= ST_RUN;
               end else if (!start_i) begin
                  if (hi_we_i) hi_q <= wdata_i;
                  if (lo_we_i) lo_q <= wdata_i;
               end
            end
            ST_RUN: begin
               if (flush_i) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == MDU_CNT_W'(MDU_ITERS - 1)) state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               cnt_q   <= '0;
               state_q <= ST_IDLE;
               if (!flush_i) begin
                  if (is_div_q) begin
                     hi_q <= rem_fix;
                     lo_q <= quo_fix;
                  end else begin
                     hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                     lo_q <= prod_fix[WIDTH-1:0];
                  end
                  done_q <= 1'b1;
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign busy_o = (state_q != ST_IDLE);
   assign done_o = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of mult/div results and
// timing, plus sequences for MTHI/MTLO, ignored start, flush and reset.
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, flush, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic [31:0] hi, lo;
   logic        busy, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op),
      .a_i(a), .b_i(b), .flush_i(flush), .hi_we_i(hi_we), .lo_we_i(lo_we),
      .wdata_i(wdata), .hi_o(hi), .lo_o(lo), .busy_o(busy), .done_o(done)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge; starts the op and returns at the negedge of the done cycle.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         if (busy) bcnt++;
         if (done) begin
            lat = n;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int lat, bcnt;
      reset = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = MDU_MULT; a = '0; b = '0; wdata = '0;

      vecs[0] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
      vecs[1] = '{MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7"};
      vecs[2] = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin"};
      vecs[3] = '{MDU_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, "multu_shift"};
      vecs[4] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2"};
      vecs[5] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dm2"};
      vecs[6] = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100d7"};
      vecs[7] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
      vecs[8] = '{MDU_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, "divu_by0"};
      vecs[9] = '{MDU_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, "div_neg_by0"};

      repeat (3) @(negedge clk);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // Each op is launched in the done cycle of the previous one.
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
         chk({vecs[i].name, "_hi"}, hi, vecs[i].hi);
         chk({vecs[i].name, "_lo"}, lo, vecs[i].lo);
         chk({vecs[i].name, "_latency"}, lat, 32'd34);
         chk({vecs[i].name, "_busy_cycles"}, bcnt, 32'd33);
         chk({vecs[i].name, "_busy_in_done"}, {31'b0, busy}, 32'h0);
      end

      // MTHI, then MULTU 2x3 with an ignored start and lo_we at cycle 10.
      @(negedge clk);
      hi_we = 1'b1; wdata = 32'h1234;
      @(negedge clk);
      hi_we = 1'b0;
      chk("mthi", hi, 32'h1234);
      op = MDU_MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      for (int n = 1; n <= 60; n++) begin
         if (done) begin
            lat = n;
            break;
         end
         if (n == 10) begin
            start = 1'b1; op = MDU_MULTU; a = 32'd7; b = 32'd7;
            lo_we = 1'b1; wdata = 32'hDEAD;
         end
         @(negedge clk);
         start = 1'b0; lo_we = 1'b0;
      end
      chk("busy_ign_latency", lat, 32'd34);
      chk("busy_ign_hi", hi, 32'h0);
      chk("busy_ign_lo", lo, 32'h6);

      // MTLO, then MULTU 5x5 flushed at cycle 20.
      @(negedge clk);
      lo_we = 1'b1; wdata = 32'hAA;
      @(negedge clk);
      lo_we = 1'b0;
      chk("mtlo", lo, 32'hAA);
      op = MDU_MULTU; a = 32'd5; b = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      chk("flush_busy_before", {31'b0, busy}, 32'h1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy_after", {31'b0, busy}, 32'h0);
      bcnt = 0;
      for (int n = 0; n < 20; n++) begin
         if (done) bcnt++;
         @(negedge clk);
      end
      chk("flush_no_done", bcnt, 32'd0);
      chk("flush_lo", lo, 32'hAA);
      chk("flush_hi", hi, 32'h0);

      // Same op interrupted by reset at cycle 20.
      op = MDU_MULTU; a = 32'd5; b = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_busy", {31'b0, busy}, 32'h0);
      chk("rst_mid_hi", hi, 32'h0);
      chk("rst_mid_lo", lo, 32'h0);
      chk("rst_mid_done", {31'b0, done}, 32'h0);

      // Unit still works after a mid-operation reset.
      run_op(MDU_DIVU, 32'd100, 32'd7, lat, bcnt);
      chk("post_rst_lo", lo, 32'd14);
      chk("post_rst_hi", hi, 32'd2);
      chk("post_rst_latency", lat, 32'd34);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit in the execute stage, beside the ALU. Takes the same forwarded rs/rt operands the ALU sees, computes MULT/MULTU/DIV/DIVU over a fixed 34-cycle latency, and holds the architectural HI/LO registers. While busy it raises `busy`, which hazard control uses to stall MFHI/MFLO and further mult/div instructions.

## Interface
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  launch operation `op` on `a`, `b`; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  rs operand (multiplicand / dividend).
- `b`  in  WIDTH  rt operand (multiplier / divisor).
- `flush`  in  1  abort in-flight operation; HI/LO unchanged.
- `hi_we`, `lo_we`  in  1 each  MTHI/MTLO write enables.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `hi`, `lo`  out  WIDTH  architectural HI/LO, registered.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO update.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `start`=1, `flush`=0: latch |a|, |b| (signed ops; raw for unsigned), result signs, op; counter←0; →RUN.
- RUN: one iteration per cycle. Multiply is shift-add into a 64-bit accumulator. Divide is restoring, one quotient bit per cycle, with a 33-bit subtract. 32 iterations, then →FIX.
- FIX: sign correction, then write HI/LO; →IDLE; `done`=1 next cycle.
  - MULT: 64-bit product negated if sign(a)≠sign(b). HI=upper, LO=lower.
  - DIV: LO=quotient, negated if signs differ. HI=remainder, sign follows dividend.
  - Unsigned ops: no correction.
- Divide by zero (b=0, either divide op): same latency; LO=all ones, HI=a. No trap.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude arithmetic with no special case.
- `start` while busy: ignored. No queueing, no effect on the running op.
- `flush` in RUN/FIX: →IDLE next edge. HI/LO untouched, no `done`.
- `flush` with `start` in IDLE: start dropped.
- `hi_we`/`lo_we`: honoured only in IDLE and not coincident with `start` (start wins, write dropped). Ignored while busy.
- Reset (any state, including mid-operation): IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0.

## Timing
- Edge E0 samples `start`. `busy`=1 from the cycle after E0 through the cycle ending at E33, so 33 cycles.
- Edges E1..E32: iterations. E33 (FIX): HI/LO written. `done`=1 in the cycle after E33; `busy`=0 in that same cycle.
- Latency from start to HI/LO visible = 34 cycles. Back-to-back start is legal in the `done` cycle.
- MTHI/MTLO in IDLE: new value visible on `hi`/`lo` the cycle after the write edge.
- `flush` takes effect at the edge on which it is sampled. `busy` is 0 the next cycle.
- `hi`/`lo` change only at FIX, on MTHI/MTLO, or on reset.

## Structure
- Shared package `mdu_pkg`:
  - op encodings (`MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`)
  - state enum
  - `MDU_ITERS`=32
- One sub-module, `mdu_abs_neg`: combinational conditional two's-complement negate (WIDTH and 2·WIDTH instances). Used for operand magnitude at start and sign fix in FIX.
- Counter width: clog2(MDU_ITERS)+1.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `done` exactly 34 cycles after start; `busy` high for 33 cycles.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 7 → LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=0x00000064.
- MTHI 0x1234 then MULTU 2×3. At cycle 10 of the MULTU: second `start` and `lo_we` both ignored. Final HI=0, LO=6.
- MTLO 0xAA in IDLE; start MULTU 5×5; `flush` at cycle 20 → `busy`=0 next cycle, no `done`, LO stays 0xAA. Repeat with `reset` instead at cycle 20 → HI=LO=0, `busy`=0.
